// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises cache-line read/write requests
// onto a single valid/ready memory command port, one transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,

  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_gnt;
  logic              gnt_id;
  logic              cur_id;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              grant;

  // On contention the port that did not win last time is served.
  always_comb begin
    gnt_id = r1_req;
    if (r0_req && r1_req) begin
      gnt_id = ~last_gnt;
    end
  end

  assign grant = (state == IDLE) && (r0_req || r1_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (r0_req || r1_req) state_nxt = ISSUE;
      ISSUE:   if (m_ready) state_nxt = cur_we ? RESP : WAIT;
      WAIT:    if (m_rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // last_gnt resets to port 1 so the first contended grant goes to port 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt  <= 1'b1;
      cur_id    <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else if (grant) begin
      last_gnt  <= gnt_id;
      cur_id    <= gnt_id;
      cur_we    <= gnt_id ? r1_we    : r0_we;
      cur_addr  <= gnt_id ? r1_addr  : r0_addr;
      cur_wdata <= gnt_id ? r1_wdata : r0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else if ((state == WAIT) && m_rvalid) begin
      if (cur_id) begin
        r1_rdata <= m_rdata;
      end else begin
        r0_rdata <= m_rdata;
      end
    end
  end

  // Every handshake/status output decodes registered state only.
  assign m_valid = (state == ISSUE);
  assign m_we    = cur_we;
  assign m_addr  = cur_addr;
  assign m_wdata = cur_wdata;
  assign r0_done = (state == RESP) && !cur_id;
  assign r1_done = (state == RESP) && cur_id;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: transaction-level scoreboard fed by the
// requester driver and checked by a cycle monitor against arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_done, r1_done;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          m_valid, m_ready, m_we, m_rvalid, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  logic          drv_req[2];
  logic          drv_we[2];
  logic [AW-1:0] drv_addr[2];
  logic [DW-1:0] drv_wdata[2];
  logic          active[2];
  int            gap[2];

  cmd_t          cmd_q[2][$];
  cmd_t          exp_q[2][$];

  logic          mem_manual, man_ready, man_rvalid;
  logic [DW-1:0] man_rdata;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          gnt_valid = 1'b0;
  logic          gnt_id, hs_done, awaiting_rv;
  int            gnt_cycle, done_exp;
  logic          model_last;
  logic [DW-1:0] shown[2];

  always #5 clk = ~clk;

  assign r0_req = drv_req[0];
  assign r0_we = drv_we[0];
  assign r0_addr = drv_addr[0];
  assign r0_wdata = drv_wdata[0];
  assign r1_req = drv_req[1];
  assign r1_we = drv_we[1];
  assign r1_addr = drv_addr[1];
  assign r1_wdata = drv_wdata[1];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_rdata(r1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a, ~a, a + 32'd1, a ^ 32'hA5A5_A5A5};
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int n);
    cmd_t c;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < n; i++) begin
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = $urandom & 32'hFFFF_FFF0;
        c.wdata = {$urandom, $urandom, $urandom, $urandom};
        cmd_q[p].push_back(c);
      end
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((cmd_q[0].size() != 0 || cmd_q[1].size() != 0 || active[0] || active[1] ||
            gnt_valid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", DW'(n < max_cycles), DW'(1'b1));
  endtask

  // Requesters: hold request and payload until done, optionally back-to-back.
  initial begin : driver
    cmd_t c;
    for (int p = 0; p < 2; p++) begin
      drv_req[p] = 1'b0; drv_we[p] = 1'b0; drv_addr[p] = '0; drv_wdata[p] = '0;
      active[p] = 1'b0; gap[p] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!rstn) begin
          active[p] = 1'b0;
          drv_req[p] = 1'b0;
        end else begin
          if (active[p] && ((p == 0) ? r0_done : r1_done)) begin
            active[p] = 1'b0;
            drv_req[p] = 1'b0;
            gap[p] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 4));
          end
          if (!active[p]) begin
            if (gap[p] > 0) begin
              gap[p]--;
            end else if (cmd_q[p].size() != 0) begin
              c = cmd_q[p].pop_front();
              drv_req[p] = 1'b1;
              drv_we[p] = c.we;
              drv_addr[p] = c.addr;
              drv_wdata[p] = c.wdata;
              exp_q[p].push_back(c);
              active[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Memory: random ready, random read latency, stray rvalid when no read is owed.
  initial begin : memory
    logic          hs, hs_we, owed;
    logic [AW-1:0] hs_addr, rd_addr;
    int            delay;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; owed = 1'b0; delay = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      hs = m_valid && m_ready;
      hs_we = m_we;
      hs_addr = m_addr;
      @(posedge clk);
      #1;
      if (mem_manual) begin
        owed = 1'b0;
        m_ready = man_ready;
        m_rvalid = man_rvalid;
        m_rdata = man_rdata;
      end else if (!rstn) begin
        owed = 1'b0;
        m_ready = 1'b0;
        m_rvalid = 1'b0;
      end else begin
        if (hs && !hs_we) begin
          owed = 1'b1;
          rd_addr = hs_addr;
          delay = int'($urandom_range(0, 4));
        end
        m_ready = ($urandom_range(0, 2) != 0);
        m_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (owed) begin
          m_rvalid = (delay == 0);
          if (delay == 0) begin
            m_rdata = mem_data(rd_addr);
            owed = 1'b0;
          end else begin
            delay--;
          end
        end else begin
          m_rvalid = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Monitor: predicts each grant from the request lines and checks every cycle.
  initial begin : monitor
    cmd_t e;
    logic gnt_was;
    logic w;
    model_last = 1'b1;
    shown[0] = '0;
    shown[1] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        check_output("reset_ctrl", DW'({m_valid, m_we, busy, r0_done, r1_done}), '0);
        check_output("reset_addr", DW'(m_addr), '0);
        check_output("reset_wdata", m_wdata, '0);
        check_output("reset_rdata0", r0_rdata, '0);
        check_output("reset_rdata1", r1_rdata, '0);
        exp_q[0].delete();
        exp_q[1].delete();
        gnt_valid = 1'b0;
        model_last = 1'b1;
        shown[0] = '0;
        shown[1] = '0;
        continue;
      end
      gnt_was = gnt_valid;
      check_output("busy", DW'(busy), DW'(gnt_was));

      if (gnt_valid && awaiting_rv && m_rvalid) begin
        done_exp = cyc + 1;
        awaiting_rv = 1'b0;
      end

      if (gnt_valid && !hs_done && cyc > gnt_cycle) begin
        check_output("m_valid", DW'(m_valid), DW'(1'b1));
        if (m_valid && exp_q[gnt_id].size() != 0) begin
          e = exp_q[gnt_id][0];
          check_output("cmd_we_addr", DW'({m_we, m_addr}), DW'({e.we, e.addr}));
          check_output("cmd_wdata", m_wdata, e.wdata);
          if (m_ready) begin
            hs_done = 1'b1;
            if (e.we) done_exp = cyc + 1;
            else awaiting_rv = 1'b1;
          end
        end
      end else begin
        check_output("m_valid_quiet", DW'(m_valid), '0);
      end

      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? r0_done : r1_done) begin
          w = gnt_valid && hs_done && (gnt_id == 1'(p)) && (cyc == done_exp);
          check_output($sformatf("done%0d_expected", p), DW'(w), DW'(1'b1));
          if (w && exp_q[p].size() != 0) begin
            e = exp_q[p].pop_front();
            if (!e.we) shown[p] = mem_data(e.addr);
            gnt_valid = 1'b0;
          end
        end
      end
      if (gnt_valid && hs_done && done_exp >= 0 && cyc >= done_exp) begin
        check_output("done_missing", '0, DW'(1'b1));
        if (exp_q[gnt_id].size() != 0) void'(exp_q[gnt_id].pop_front());
        gnt_valid = 1'b0;
      end
      if (gnt_valid && (cyc - gnt_cycle) > 100) begin
        check_output("txn_timeout", '0, DW'(1'b1));
        gnt_valid = 1'b0;
      end

      check_output("rdata0", r0_rdata, shown[0]);
      check_output("rdata1", r1_rdata, shown[1]);

      if (!gnt_was && (r0_req || r1_req)) begin
        gnt_id = (r0_req && r1_req) ? ~model_last : r1_req;
        model_last = gnt_id;
        gnt_valid = 1'b1;
        gnt_cycle = cyc;
        hs_done = 1'b0;
        awaiting_rv = 1'b0;
        done_exp = -1;
        check_output("grant_has_payload", DW'(exp_q[gnt_id].size() != 0), DW'(1'b1));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    cmd_t c;
    int   n;
    rstn = 1'b0;
    mem_manual = 1'b0;
    man_ready = 1'b0;
    man_rvalid = 1'b0;
    man_rdata = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Both ports loaded together: first contended grant must go to port 0.
    apply_stimulus(40);
    wait_drain(6000);

    // Stalled read, then reset while waiting for data, then a late rvalid.
    mem_manual = 1'b1;
    c.we = 1'b0;
    c.addr = 32'h0000_0100;
    c.wdata = '0;
    cmd_q[0].push_back(c);
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_issue", DW'(m_valid), DW'(1'b1));
    repeat (3) @(negedge clk);
    man_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!(m_valid && m_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_accept", DW'(m_valid && m_ready), DW'(1'b1));
    man_ready = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata = {4{32'hDEAD_BEEF}};
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("late_rvalid_rdata0", r0_rdata, '0);
    check_output("late_rvalid_busy", DW'(busy), '0);
    mem_manual = 1'b0;

    apply_stimulus(12);
    wait_drain(3000);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
